// File: rtl/icache_refill_if.sv
// Fetch-side and instruction-memory signals of the I-cache line refill engine.
// The refill engine uses the slave modport; the fetch stage and memory side use master.
interface icache_refill_if #(
  parameter int DATA_WIDTH = 32,
  parameter int BLOCK_SIZE = 4
);
  logic                             req_valid;
  logic [31:0]                      req_addr;
  logic                             cache_hit;
  logic                             flush;
  logic                             mem_rd_en;
  logic [31:0]                      mem_addr;
  logic                             mem_ready;
  logic                             mem_rvalid;
  logic [DATA_WIDTH-1:0]            mem_rdata;
  logic [BLOCK_SIZE*DATA_WIDTH-1:0] fetch_data;
  logic                             fetch_enable;
  logic                             stall;

  modport slave (
    input  req_valid, req_addr, cache_hit, flush, mem_ready, mem_rvalid, mem_rdata,
    output mem_rd_en, mem_addr, fetch_data, fetch_enable, stall
  );

  modport master (
    output req_valid, req_addr, cache_hit, flush, mem_ready, mem_rvalid, mem_rdata,
    input  mem_rd_en, mem_addr, fetch_data, fetch_enable, stall
  );
endinterface

// File: rtl/icache_refill.sv
// Instruction-cache line refill: fetches the four words of a missing line one
// request at a time, then pulses fetch_enable with the assembled line.
module icache_refill #(
  parameter int DATA_WIDTH = 32,
  parameter int BLOCK_SIZE = 4
) (
  input  logic            clk,
  input  logic            rst,
  icache_refill_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_FILL  = 3'd3,
    S_DRAIN = 3'd4
  } state_e;

  state_e                           state_q, state_d;
  logic [1:0]                       cnt_q, cnt_d;
  logic [31:0]                      line_base_q, line_base_d;
  logic [BLOCK_SIZE*DATA_WIDTH-1:0] data_q, data_d;
  logic                             miss;

  assign miss = bus.req_valid && !bus.cache_hit && !bus.flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 2'd0;
      line_base_q <= 32'd0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      line_base_q <= line_base_d;
      data_q      <= data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    line_base_d = line_base_q;
    data_d      = data_q;
    case (state_q)
      S_IDLE: begin
        if (miss) begin
          state_d     = S_REQ;
          line_base_d = bus.req_addr & 32'hFFFF_FFF0;
          cnt_d       = 2'd0;
        end
      end
      S_REQ: begin
        // an accepted request still owes a response, so a flush must drain it
        if (bus.flush)          state_d = bus.mem_ready ? S_DRAIN : S_IDLE;
        else if (bus.mem_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.flush) begin
          state_d = bus.mem_rvalid ? S_IDLE : S_DRAIN;
        end else if (bus.mem_rvalid) begin
          data_d[cnt_q*DATA_WIDTH +: DATA_WIDTH] = bus.mem_rdata;
          if (cnt_q == 2'd3) begin
            state_d = S_FILL;
          end else begin
            cnt_d   = cnt_q + 2'd1;
            state_d = S_REQ;
          end
        end
      end
      S_FILL:  state_d = S_IDLE;
      S_DRAIN: if (bus.mem_rvalid) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.mem_rd_en    = (state_q == S_REQ);
    bus.mem_addr     = (state_q == S_REQ) ? (line_base_q + {28'd0, cnt_q, 2'b00}) : 32'd0;
    bus.fetch_enable = (state_q == S_FILL);
    bus.fetch_data   = data_q;
    bus.stall        = ((state_q == S_IDLE) && miss) || (state_q == S_REQ) ||
                       (state_q == S_WAIT) || (state_q == S_DRAIN);
  end

endmodule
